// File: rtl/password_entry_controller.sv
// Six-digit keypad lock sequencer: digit entry, compare, timed fail/lockout/unlock
// dwell, and password change while open. All outputs come straight from registers.
module password_entry_controller #(
  parameter logic [23:0] DEFAULT_PW    = 24'h123456,
  parameter int          MAX_FAIL      = 3,
  parameter int          FAIL_CYCLES   = 50,
  parameter int          LOCK_CYCLES   = 1000,
  parameter int          UNLOCK_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_key_back,
  input  logic       i_key_clear,
  input  logic       i_set_req,
  output logic [2:0] o_count,
  output logic       o_unlocked,
  output logic       o_fail,
  output logic       o_locked_out,
  output logic       o_set_mode,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_ENTRY    = 3'd0,
    S_CHECK    = 3'd1,
    S_FAIL     = 3'd2,
    S_LOCKOUT  = 3'd3,
    S_UNLOCKED = 3'd4,
    S_SET      = 3'd5
  } state_t;

  localparam int MAX_A = (FAIL_CYCLES > LOCK_CYCLES) ? FAIL_CYCLES : LOCK_CYCLES;
  localparam int MAX_C = (MAX_A > UNLOCK_CYCLES) ? MAX_A : UNLOCK_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  state_t        r_state;
  logic [2:0]    r_count;
  logic [23:0]   r_buf;
  logic [23:0]   r_pw;
  logic [2:0]    r_fail_cnt;
  logic [TW-1:0] r_timer;
  logic          r_unlocked;
  logic          r_fail;
  logic          r_locked_out;
  logic          r_set_mode;

  logic w_clear;
  logic w_back;
  logic w_digit;
  logic w_last;
  logic w_match;
  logic w_lock_hit;
  logic w_timer_zero;
  logic w_keys_live;

  // Only the highest-priority strobe acts: clear > back > digit.
  assign w_keys_live  = (r_state == S_ENTRY) || (r_state == S_SET);
  assign w_clear      = i_key_clear;
  assign w_back       = !i_key_clear && i_key_back;
  assign w_digit      = !i_key_clear && !i_key_back && i_key_valid &&
                        (i_key_digit <= 4'd9) && (r_count < 3'd6);
  assign w_last       = w_digit && (r_count == 3'd5);
  assign w_match      = (r_buf == r_pw);
  assign w_lock_hit   = (({1'b0, r_fail_cnt} + 4'd1) == 4'(MAX_FAIL));
  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_ENTRY;
      r_count      <= 3'd0;
      r_buf        <= 24'd0;
      r_pw         <= DEFAULT_PW;
      r_fail_cnt   <= 3'd0;
      r_timer      <= '0;
      r_unlocked   <= 1'b0;
      r_fail       <= 1'b0;
      r_locked_out <= 1'b0;
      r_set_mode   <= 1'b0;
    end else begin
      // Slot k holds the k-th digit entered, first digit in the top nibble.
      if (w_keys_live && w_digit) begin
        for (int i = 0; i < 6; i++) begin
          if (r_count == 3'(i)) r_buf[23-4*i -: 4] <= i_key_digit;
        end
      end

      case (r_state)
        S_ENTRY: begin
          if (w_clear)                          r_count <= 3'd0;
          else if (w_back && r_count != 3'd0)   r_count <= r_count - 3'd1;
          else if (w_digit)                     r_count <= r_count + 3'd1;
          if (w_last) r_state <= S_CHECK;
        end

        S_CHECK: begin
          if (w_match) begin
            r_fail_cnt <= 3'd0;
            r_state    <= S_UNLOCKED;
            r_unlocked <= 1'b1;
            r_timer    <= TW'(UNLOCK_CYCLES - 1);
          end else if (w_lock_hit) begin
            r_fail_cnt   <= 3'd0;
            r_count      <= 3'd0;
            r_state      <= S_LOCKOUT;
            r_locked_out <= 1'b1;
            r_timer      <= TW'(LOCK_CYCLES - 1);
          end else begin
            r_fail_cnt <= r_fail_cnt + 3'd1;
            r_count    <= 3'd0;
            r_state    <= S_FAIL;
            r_fail     <= 1'b1;
            r_timer    <= TW'(FAIL_CYCLES - 1);
          end
        end

        S_FAIL: begin
          if (w_timer_zero) begin
            r_state <= S_ENTRY;
            r_fail  <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        S_LOCKOUT: begin
          if (w_timer_zero) begin
            r_state      <= S_ENTRY;
            r_locked_out <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        S_UNLOCKED: begin
          if (i_key_clear || w_timer_zero) begin
            r_state    <= S_ENTRY;
            r_count    <= 3'd0;
            r_unlocked <= 1'b0;
          end else if (i_set_req) begin
            r_state    <= S_SET;
            r_count    <= 3'd0;
            r_unlocked <= 1'b0;
            r_set_mode <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        S_SET: begin
          if (w_clear) begin
            r_count <= 3'd0;
            // A clear on an empty entry abandons the change.
            if (r_count == 3'd0) begin
              r_state    <= S_ENTRY;
              r_set_mode <= 1'b0;
            end
          end else if (w_back) begin
            if (r_count != 3'd0) r_count <= r_count - 3'd1;
          end else if (w_last) begin
            r_pw       <= {r_buf[23:4], i_key_digit};
            r_count    <= 3'd0;
            r_state    <= S_ENTRY;
            r_set_mode <= 1'b0;
          end else if (w_digit) begin
            r_count <= r_count + 3'd1;
          end
        end

        default: begin
          r_state      <= S_ENTRY;
          r_count      <= 3'd0;
          r_unlocked   <= 1'b0;
          r_fail       <= 1'b0;
          r_locked_out <= 1'b0;
          r_set_mode   <= 1'b0;
        end
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_unlocked   = r_unlocked;
  assign o_fail       = r_fail;
  assign o_locked_out = r_locked_out;
  assign o_set_mode   = r_set_mode;
  assign o_state      = r_state;

endmodule

// File: tb/tb_password_entry_controller.sv
// Directed bench for password_entry_controller: vector tables for keypad traces,
// hand-written sequences for dwell timing, lockout, password change and async reset.
module tb_password_entry_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_back;
  logic       key_clear;
  logic       set_req;
  logic [2:0] count;
  logic       unlocked;
  logic       fail;
  logic       locked_out;
  logic       set_mode;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  password_entry_controller dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_key_valid  (key_valid),
    .i_key_digit  (key_digit),
    .i_key_back   (key_back),
    .i_key_clear  (key_clear),
    .i_set_req    (set_req),
    .o_count      (count),
    .o_unlocked   (unlocked),
    .o_fail       (fail),
    .o_locked_out (locked_out),
    .o_set_mode   (set_mode),
    .o_state      (state)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       b;
    logic       c;
    logic       s;
    logic [2:0] cnt;
    logic [3:0] flags;  // {unlocked, fail, locked_out, set_mode}
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_UNL  = 4'b1000;
  localparam logic [3:0] F_FAIL = 4'b0100;
  localparam logic [3:0] F_LOCK = 4'b0010;
  localparam logic [3:0] F_SET  = 4'b0001;

  task automatic push(input logic v, input logic [3:0] d, input logic b, input logic c,
                      input logic s, input logic [2:0] cnt, input logic [3:0] flags);
    vec_t t;
    t.v = v; t.d = d; t.b = b; t.c = c; t.s = s; t.cnt = cnt; t.flags = flags;
    vq.push_back(t);
  endtask

  // Six digits of a code typed from count 0 in ENTRY: counts 1..6, no flags.
  task automatic push_code(input logic [23:0] code);
    for (int k = 0; k < 6; k++) push(1'b1, code[23-4*k -: 4], 1'b0, 1'b0, 1'b0, 3'(k + 1), F_NONE);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic b, input logic c,
                       input logic s);
    key_valid = v; key_digit = d; key_back = b; key_clear = c; set_req = s;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_digit = 4'd0; key_back = 1'b0; key_clear = 1'b0; set_req = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [2:0] cnt, input logic [3:0] flags);
    logic [3:0] act;
    act = {unlocked, fail, locked_out, set_mode};
    checks++;
    if (count !== cnt || act !== flags) begin
      errors++;
      $display("FAIL %s: count=%0d flags(u,f,l,s)=%b, expected count=%0d flags=%b",
               name, count, act, cnt, flags);
    end
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].d, vq[i].b, vq[i].c, vq[i].s);
      expect_out($sformatf("%s[%0d]", tag, i), vq[i].cnt, vq[i].flags);
    end
    vq.delete();
  endtask

  // The timed flag has already been seen for one cycle; it must hold for the
  // remaining n-1 edges and drop on the n-th, returning to ENTRY with count 0.
  task automatic dwell(input string name, input int n, input logic [3:0] flags,
                       input logic [2:0] cnt, input bit press);
    int good = 0;
    for (int i = 0; i < n - 1; i++) begin
      if (press) drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      else       drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      if ({unlocked, fail, locked_out, set_mode} === flags && count === cnt) good++;
    end
    checks++;
    if (good != n - 1) begin
      errors++;
      $display("FAIL %s_hold: cycles held=%0d, expected %0d", name, good, n - 1);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_out({name, "_exit"}, 3'd0, F_NONE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0; key_back = 1'b0; key_clear = 1'b0; set_req = 1'b0;
    #1;
    expect_out("reset_outputs", 3'd0, F_NONE);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d, expected 0", state);
    end
    #22 reset = 1'b0;
    @(posedge clk);
    #1;

    // Correct code, unlock after two edges, 500-cycle dwell.
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    run_vecs("t1_unlock");
    dwell("t1_unlocked", 500, F_UNL, 3'd6, 1'b0);

    // Three mismatches: fail, fail, lockout (keys ignored), then unlock.
    for (int r = 0; r < 2; r++) begin
      push_code(24'h123457);
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, F_FAIL);
      run_vecs($sformatf("t2_bad%0d", r));
      dwell($sformatf("t2_fail%0d", r), 50, F_FAIL, 3'd0, 1'b0);
    end
    push_code(24'h123457);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, F_LOCK);
    run_vecs("t2_bad2");
    dwell("t2_lockout", 1000, F_LOCK, 3'd0, 1'b1);
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    run_vecs("t2_recover");

    // Backspace trace, invalid digit, strobe priorities.
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, F_NONE);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 3'd3, F_NONE);
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd1, F_NONE);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3'd3, F_NONE);
    push(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 3'd4, F_NONE);
    push(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 3'd5, F_NONE);
    push(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 3'd6, F_NONE);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, F_NONE);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, F_NONE);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3'd3, F_NONE);
    push(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 3'd3, F_NONE);
    push(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    run_vecs("t3_trace");

    // Change password to 987654; old code now fails, new one unlocks.
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0, F_SET);
    push(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 3'd1, F_SET);
    push(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, F_SET);
    push(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 3'd3, F_SET);
    push(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 3'd4, F_SET);
    push(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 3'd5, F_SET);
    push(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE);
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, F_FAIL);
    run_vecs("t4_set");
    dwell("t4_oldpw_fail", 50, F_FAIL, 3'd0, 1'b0);
    push_code(24'h987654);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    run_vecs("t4_newpw");

    // Aborted change keeps 987654; then async reset mid-entry.
    push_code(24'h987654);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0, F_SET);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, F_SET);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, F_SET);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_SET);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    push_code(24'h987654);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3'd1, F_NONE);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd2, F_NONE);
    push(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3'd3, F_NONE);
    run_vecs("t5_abort");
    reset = 1'b1;
    #1;
    expect_out("t5_async_reset", 3'd0, F_NONE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    run_vecs("t5_default_pw");

    // Two mismatches, a match, one mismatch: must be FAIL, not LOCKOUT.
    for (int r = 0; r < 2; r++) begin
      push_code(24'h111111);
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, F_FAIL);
      run_vecs($sformatf("t6_bad%0d", r));
      dwell($sformatf("t6_fail%0d", r), 50, F_FAIL, 3'd0, 1'b0);
    end
    push_code(24'h123456);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd6, F_UNL);
    push(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, F_NONE);
    push_code(24'h111111);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, F_FAIL);
    run_vecs("t6_after_match");
    dwell("t6_fail_again", 50, F_FAIL, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
